// File: rtl/apb_timer_ctrl_if.sv
// ---------------------------------------------------------------------------
// apb_timer_ctrl_if
//   APB bus bundle between the timer sequencer (master) and the 8-bit APB
//   timer slave.
//   Signals:
//     psel, penable, pwrite  master -> slave  transfer controls
//     paddr[7:0]             master -> slave  register address
//     pwdata[7:0]            master -> slave  write data
//     prdata[7:0]            slave -> master  read data
//     pready                 slave -> master  transfer ready
//     pslverr                slave -> master  transfer error
// ---------------------------------------------------------------------------
interface apb_timer_ctrl_if;
  logic       psel;
  logic       penable;
  logic       pwrite;
  logic [7:0] paddr;
  logic [7:0] pwdata;
  logic [7:0] prdata;
  logic       pready;
  logic       pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/apb_timer_ctrl.sv
// ---------------------------------------------------------------------------
// apb_timer_ctrl
//   APB master sequencer for the 8-bit APB timer slave (TCR @0x00,
//   TSR @0x01, TDR @0x02). A start programs TDR, loads and enables the
//   counter, then polls TSR; every overflow/underflow found is reported as a
//   one-cycle pulse, counted, and cleared in TSR.
//   Ports:
//     pclk, preset_n      clock, asynchronous active-low reset
//     start, stop         command pulses (start only accepted while idle)
//     cfg_val             counter preload written to TDR
//     cfg_clk_s           clock select, TCR[1:0]
//     cfg_updown, cfg_ie  count direction TCR[5], interrupt enable TCR[3]
//     cfg_oneshot         stop the sequence after the first event
//     apb                 APB master port (interface)
//     busy                sequence in progress
//     evt_ovf, evt_udf    one-cycle pulses for TSR[0] / TSR[1]
//     evt_cnt             saturating event count since the last start
//     err                 sticky slave error / timeout flag
// ---------------------------------------------------------------------------
module apb_timer_ctrl #(
  parameter int POLL_GAP = 16,
  parameter int TIMEOUT  = 15,
  parameter int CNT_W    = 8
) (
  input  logic             pclk,
  input  logic             preset_n,
  input  logic             start,
  input  logic             stop,
  input  logic [7:0]       cfg_val,
  input  logic [1:0]       cfg_clk_s,
  input  logic             cfg_updown,
  input  logic             cfg_ie,
  input  logic             cfg_oneshot,
  apb_timer_ctrl_if.master apb,
  output logic             busy,
  output logic             evt_ovf,
  output logic             evt_udf,
  output logic [CNT_W-1:0] evt_cnt,
  output logic             err
);

  localparam int GAP_W = $clog2(POLL_GAP + 1);
  localparam int TMO_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WR_TDR, S_WR_LOAD, S_WR_RUN,
    S_POLL_WAIT, S_RD_TSR, S_WR_CLR, S_WR_STOP
  } state_e;

  state_e           state_q, state_d;
  logic             access_q, access_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic             stop_pend_q, stop_pend_d;
  logic [7:0]       cfg_val_q, cfg_val_d;
  logic [1:0]       cfg_clk_s_q, cfg_clk_s_d;
  logic             cfg_updown_q, cfg_updown_d;
  logic             cfg_ie_q, cfg_ie_d;
  logic             cfg_oneshot_q, cfg_oneshot_d;
  logic             err_q, err_d;
  logic             evt_ovf_q, evt_ovf_d;
  logic             evt_udf_q, evt_udf_d;
  logic [CNT_W-1:0] evt_cnt_q, evt_cnt_d;

  logic             unused_prdata;
  assign unused_prdata = ^apb.prdata[7:2];

  // APB drive is decoded from the registered state only, so an async reset
  // forces every bus output low without waiting for a clock edge.
  always_comb begin
    apb.psel    = 1'b1;
    apb.pwrite  = 1'b1;
    apb.paddr   = 8'h00;
    apb.pwdata  = 8'h00;
    case (state_q)
      S_WR_TDR: begin
        apb.paddr  = 8'h02;
        apb.pwdata = cfg_val_q;
      end
      S_WR_LOAD: apb.pwdata = {1'b1, 1'b0, cfg_updown_q, 1'b0, cfg_ie_q, 1'b0, cfg_clk_s_q};
      S_WR_RUN:  apb.pwdata = {1'b0, 1'b0, cfg_updown_q, 1'b1, cfg_ie_q, 1'b0, cfg_clk_s_q};
      S_RD_TSR: begin
        apb.paddr  = 8'h01;
        apb.pwrite = 1'b0;
      end
      S_WR_CLR:  apb.paddr = 8'h01;
      S_WR_STOP: apb.paddr = 8'h00;
      default: begin
        apb.psel   = 1'b0;
        apb.pwrite = 1'b0;
      end
    endcase
    apb.penable = apb.psel & access_q;
  end

  // Sequencer next state. Transfer states share one SETUP/ACCESS engine;
  // a pending stop redirects to WR_STOP only once the current transfer has
  // completed, while a slave error or timeout abandons the sequence at once.
  always_comb begin
    state_d       = state_q;
    access_d      = access_q;
    tmo_d         = tmo_q;
    gap_d         = gap_q;
    stop_pend_d   = stop_pend_q;
    cfg_val_d     = cfg_val_q;
    cfg_clk_s_d   = cfg_clk_s_q;
    cfg_updown_d  = cfg_updown_q;
    cfg_ie_d      = cfg_ie_q;
    cfg_oneshot_d = cfg_oneshot_q;
    err_d         = err_q;
    evt_cnt_d     = evt_cnt_q;
    evt_ovf_d     = 1'b0;
    evt_udf_d     = 1'b0;

    if (stop && state_q != S_IDLE) stop_pend_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          cfg_val_d     = cfg_val;
          cfg_clk_s_d   = cfg_clk_s;
          cfg_updown_d  = cfg_updown;
          cfg_ie_d      = cfg_ie;
          cfg_oneshot_d = cfg_oneshot;
          err_d         = 1'b0;
          evt_cnt_d     = '0;
          access_d      = 1'b0;
          tmo_d         = '0;
          state_d       = S_WR_TDR;
        end
      end
      S_POLL_WAIT: begin
        access_d = 1'b0;
        tmo_d    = '0;
        if (stop || stop_pend_q) begin
          state_d = S_WR_STOP;
        end else if (gap_q == GAP_W'(POLL_GAP - 1)) begin
          state_d = S_RD_TSR;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: begin
        if (!access_q) begin
          access_d = 1'b1;
          tmo_d    = '0;
        end else if (apb.pready) begin
          access_d = 1'b0;
          tmo_d    = '0;
          gap_d    = '0;
          if (apb.pslverr) begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end else begin
            case (state_q)
              S_WR_TDR:  state_d = S_WR_LOAD;
              S_WR_LOAD: state_d = S_WR_RUN;
              S_WR_RUN:  state_d = S_POLL_WAIT;
              S_RD_TSR: begin
                evt_ovf_d = apb.prdata[0];
                evt_udf_d = apb.prdata[1];
                if ((|apb.prdata[1:0]) && (evt_cnt_q != {CNT_W{1'b1}})) begin
                  evt_cnt_d = evt_cnt_q + 1'b1;
                end
                state_d = (apb.prdata[1:0] == 2'b00) ? S_POLL_WAIT : S_WR_CLR;
              end
              S_WR_CLR:  state_d = cfg_oneshot_q ? S_WR_STOP : S_POLL_WAIT;
              default:   state_d = S_IDLE;
            endcase
            if ((stop || stop_pend_q) && state_q != S_WR_STOP) state_d = S_WR_STOP;
          end
        end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
          access_d = 1'b0;
          err_d    = 1'b1;
          state_d  = S_IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
    endcase

    if (state_d == S_IDLE) stop_pend_d = 1'b0;
  end

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      state_q       <= S_IDLE;
      access_q      <= 1'b0;
      tmo_q         <= '0;
      gap_q         <= '0;
      stop_pend_q   <= 1'b0;
      cfg_val_q     <= 8'h00;
      cfg_clk_s_q   <= 2'b00;
      cfg_updown_q  <= 1'b0;
      cfg_ie_q      <= 1'b0;
      cfg_oneshot_q <= 1'b0;
      err_q         <= 1'b0;
      evt_ovf_q     <= 1'b0;
      evt_udf_q     <= 1'b0;
      evt_cnt_q     <= '0;
    end else begin
      state_q       <= state_d;
      access_q      <= access_d;
      tmo_q         <= tmo_d;
      gap_q         <= gap_d;
      stop_pend_q   <= stop_pend_d;
      cfg_val_q     <= cfg_val_d;
      cfg_clk_s_q   <= cfg_clk_s_d;
      cfg_updown_q  <= cfg_updown_d;
      cfg_ie_q      <= cfg_ie_d;
      cfg_oneshot_q <= cfg_oneshot_d;
      err_q         <= err_d;
      evt_ovf_q     <= evt_ovf_d;
      evt_udf_q     <= evt_udf_d;
      evt_cnt_q     <= evt_cnt_d;
    end
  end

  assign busy    = (state_q != S_IDLE);
  assign evt_ovf = evt_ovf_q;
  assign evt_udf = evt_udf_q;
  assign evt_cnt = evt_cnt_q;
  assign err     = err_q;

endmodule
